// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding and the byte-enable width helper.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Word storage for dmem_responder: one lane-masked synchronous write port,
// one asynchronous read port. Contents are defined only by the clear sweep.
import dmem_responder_pkg::*;

module dmem_array #(
  parameter int DW  = 32,
  parameter int DMW = 4,
  parameter int BEW = be_width(DW)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [DMW-1:0] waddr,
  input  logic [DW-1:0]  wdata,
  input  logic [BEW-1:0] wbe,
  input  logic [DMW-1:0] raddr,
  output logic [DW-1:0]  rdata
);

  logic [DW-1:0] mem [2**DMW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BEW; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store target: clears the array after reset, then serves
// one request per handshake with a registered, backpressure-tolerant response.
//
// state   | meaning
// ST_INIT | clear sweep, one word per cycle; no requests accepted
// ST_IDLE | no response pending; ready for a request
// ST_RESP | response held on rsp_*; new request accepted only with rsp_ready
import dmem_responder_pkg::*;

module dmem_responder #(
  parameter int DW  = 32,
  parameter int DMW = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DMW+1:0]        req_addr,
  input  logic [DW-1:0]         req_wdata,
  input  logic [be_width(DW)-1:0] req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int BEW = be_width(DW);

  state_t         state, state_nxt;
  logic [DMW-1:0] clr_cnt;
  logic           accept, aligned, clr_last;
  logic           mem_we;
  logic [DMW-1:0] mem_waddr;
  logic [DW-1:0]  mem_wdata;
  logic [BEW-1:0] mem_be;
  logic [DW-1:0]  mem_rdata;

  assign req_ready = (state == ST_IDLE) || (state == ST_RESP && rsp_ready);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid && req_ready;
  assign aligned   = (req_addr[1:0] == 2'b00);
  assign clr_last  = (clr_cnt == {DMW{1'b1}});

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_waddr = req_addr[DMW+1:2];
    mem_wdata = req_wdata;
    mem_be    = req_be;
    case (state)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = '0;
        mem_be    = '1;
        if (clr_last) state_nxt = ST_IDLE;
      end
      ST_IDLE: if (accept) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready && !accept) state_nxt = ST_IDLE;
      default: state_nxt = ST_INIT;
    endcase
    // Misaligned stores never touch the array.
    if (accept && req_we && aligned) mem_we = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_last) init_done <= 1'b1;
      end
      if (accept) begin
        rsp_err   <= !aligned;
        rsp_rdata <= (aligned && !req_we) ? mem_rdata : '0;
      end
    end
  end

  dmem_array #(.DW(DW), .DMW(DMW), .BEW(BEW)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .wbe   (mem_be),
    .raddr (req_addr[DMW+1:2]),
    .rdata (mem_rdata)
  );

endmodule
